// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store buffer: FSM states and the queued store entry.
package dmem_pkg;

    localparam int unsigned SbAw = 32;
    localparam int unsigned SbDw = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWrite = 2'b01,
        StRead  = 2'b10,
        StRdone = 2'b11
    } sb_state_e;

    // Word address only; byte offset bits are dropped at enqueue.
    typedef struct packed {
        logic [SbAw-1:2] waddr;
        logic [SbDw-1:0] data;
    } sb_entry_t;

    function automatic logic [SbAw-1:0] word_addr(input logic [SbAw-1:2] waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/dmem_sb_fifo.sv
// Circular store-entry queue with head/tail/count; exposes every slot and its valid bit.
module dmem_sb_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  sb_entry_t       push_entry,
    input  logic            pop,
    output sb_entry_t       head_entry,
    output sb_entry_t       next_entry,
    output sb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PtrW-1:0] head_ptr,
    output logic [CntW-1:0] count,
    output logic            full
);

    sb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] off;
    logic            do_push, do_pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & (count_q != '0);
    assign count    = count_q;
    assign head_ptr = head_q;

    assign head_entry = mem_q[head_q];
    assign next_entry = mem_q[head_q + PtrW'(1)];
    assign entries    = mem_q;

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        off   = '0;
        valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            off      = PtrW'(i) - head_q;
            valid[i] = (CntW'(off) < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between core data port and memory bus; loads drain-then-read.
// Optional load-to-store forwarding is enabled by defining DMEM_STORE_FWD_EN.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = SbDw,
    parameter int unsigned AW    = SbAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_dm,
    input  logic          re_dm,
    input  logic [AW-1:0] alu_out,
    input  logic [DW-1:0] wd_dm,
    output logic [DW-1:0] rd_dm,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    sb_state_e       state_q, state_d;
    logic            mem_req_d, mem_we_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d, rd_dm_q, rd_dm_d;
    logic            store, load, push, pop, full;
    logic [CntW-1:0] count;
    logic [PtrW-1:0] head_ptr;
    sb_entry_t       push_entry, head_entry, next_entry;
    sb_entry_t       fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;
    logic            unused_bits;

    // A simultaneous store and load is taken as a store.
    assign store      = we_dm;
    assign load       = re_dm & ~we_dm;
    assign push       = store & ~full;
    assign push_entry = '{waddr: alu_out[AW-1:2], data: wd_dm};

    dmem_sb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head_entry(head_entry),
        .next_entry(next_entry),
        .entries   (fifo_entries),
        .valid     (fifo_valid),
        .head_ptr  (head_ptr),
        .count     (count),
        .full      (full)
    );

`ifdef DMEM_STORE_FWD_EN
    logic [PtrW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (load && (state_q == StIdle || state_q == StWrite)) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                fwd_idx = head_ptr + PtrW'(k);
                if (fifo_valid[fwd_idx] && (fifo_entries[fwd_idx].waddr == alu_out[AW-1:2])) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_entries[fwd_idx].data;
                end
            end
        end
    end

    assign unused_bits = ^alu_out[1:0];
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;

    always_comb begin
        unused_bits = (^alu_out[1:0]) ^ (^fifo_valid) ^ (^head_ptr);
        for (int k = 0; k < int'(DEPTH); k++) begin
            unused_bits = unused_bits ^ (^fifo_entries[k]);
        end
    end
`endif

    assign rd_dm = fwd_hit ? fwd_data : rd_dm_q;

    always_comb begin
        stall = 1'b0;
        if (store) begin
            stall = full;
        end else if (load) begin
            stall = (state_q != StRdone) && !fwd_hit;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rd_dm_d     = rd_dm_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count != '0) begin
                    state_d     = StWrite;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr(head_entry.waddr);
                    mem_wdata_d = head_entry.data;
                end else if (push) begin
                    // Empty queue: put the arriving store on the bus next cycle.
                    state_d     = StWrite;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr(push_entry.waddr);
                    mem_wdata_d = push_entry.data;
                end else if (load && !fwd_hit) begin
                    state_d    = StRead;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {alu_out[AW-1:2], 2'b00};
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    if (count > CntW'(1)) begin
                        mem_addr_d  = word_addr(next_entry.waddr);
                        mem_wdata_d = next_entry.data;
                    end else if (push) begin
                        mem_addr_d  = word_addr(push_entry.waddr);
                        mem_wdata_d = push_entry.data;
                    end else begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                    end
                end
            end
            StRead: begin
                if (mem_ack) begin
                    rd_dm_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = StRdone;
                end
            end
            StRdone: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_dm_q   <= '0;
        end else begin
            state_q   <= state_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rd_dm_q   <= rd_dm_d;
        end
    end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write store buffer between the MIPS core's data-memory port and the shared memory bus. Core stores (`wd_dm` to address `alu_out`) are queued and retire without waiting for the bus. Queued stores drain in order over a req/ack handshake. Core loads stall until the buffer is drained and the read returns; `rd_dm` is then delivered to the core.

## Interface
- `DEPTH`, 4: store entries; power of two, ≥2
- `DW`, 32: data width
- `AW`, 32: byte address width; bits [1:0] ignored (word access only)
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `we_dm` in 1: core store request this cycle
- `re_dm` in 1: core load request this cycle
- `alu_out` in AW: core byte address
- `wd_dm` in DW: core store data
- `rd_dm` out DW: load data to core
- `stall` out 1: combinational; core must hold its request while high
- `mem_req` out 1: bus request, registered
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`
- `mem_addr` out AW: word-aligned address, [1:0]=0
- `mem_wdata` out DW: write data
- `mem_ack` in 1: transfer completes on an edge where `mem_req && mem_ack`
- `mem_rdata` in DW: read data, valid with `mem_ack`

## Operation
- Reset values: `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, `rd_dm`=0, count=0, pointers=0, state IDLE.
- `stall` is 0 whenever `we_dm`=`re_dm`=0.
- `we_dm` and `re_dm` together is illegal; the block treats the pair as a store.
- FSM states: IDLE, WRITE, READ, RDONE.
- **Store path**
  - `we_dm` with count<DEPTH: the store enqueues at tail on the edge and `stall`=0.
  - When full, `stall`=1 until count<DEPTH, even in a cycle where a pop occurs.
- **IDLE**
  - count>0 → WRITE: drive the head entry with `mem_req`=1, `mem_we`=1.
  - Otherwise, `re_dm` with count=0 → READ with `mem_req`=1, `mem_we`=0.
- **WRITE**
  - On ack, pop the head.
  - If entries remain after the pop, stay in WRITE and present the next entry back-to-back.
  - Otherwise go to IDLE with `mem_req`=0.
- **READ**
  - On ack, capture `mem_rdata` into `rd_dm` and go to RDONE.
  - `mem_req`=0 in RDONE.
- **RDONE**
  - `stall`=0 so the core retires the load.
  - Next state is IDLE.
- Load stall: `stall`=1 for `re_dm` in IDLE, WRITE and READ.
- Ordering: a load never overtakes a buffered store. Stores arriving during a drain append to the tail.
- Simultaneous enqueue and pop: count unchanged; head and tail pointers both advance.
- Pointers wrap modulo DEPTH.
- `mem_addr`, `mem_wdata` and `mem_we` hold stable while `mem_req`=1 and no ack.
- Reset mid-transfer: `mem_req` drops immediately (asynchronous), queued stores are discarded and the FSM returns to IDLE.

## Timing
- Store to non-full buffer: 0 stall cycles.
- First write on the bus: `mem_req` rises the cycle after enqueue.
- Load, empty buffer, ack in first request cycle:
  - cycle 0: `re_dm`, `stall`=1
  - cycle 1: READ, `mem_req`=1, ack
  - cycle 2: RDONE, `stall`=0, `rd_dm` valid
  - Total: 2 stall cycles.
- Load behind N stores with immediate acks: N+2 stall cycles.
- Each bus wait state adds 1 cycle.

## Configuration
- `DMEM_STORE_FWD_EN` defined: load-to-store forwarding.
  - In IDLE or WRITE, when `re_dm` address[AW-1:2] matches any valid entry, the youngest match's data drives `rd_dm` combinationally.
  - `stall`=0 and no bus read is issued.
  - The head entry being written counts as valid until popped.
- Undefined: no compare logic; all loads follow the drain-then-read path.

## Structure
- Package `dmem_pkg`:
  - FSM state enum
  - entry struct {word address [AW-1:2], data [DW-1:0]}
  - state encodings
- Sub-module `dmem_sb_fifo`:
  - circular entry array with head/tail/count and push/pop
  - exposes all entries and valid bits for forwarding compare
- Top level holds the FSM, stall logic and bus registers.

## Test plan
- Reset asserted mid-WRITE with 3 queued → `mem_req`=0 at once; after release, count=0, IDLE, no further bus traffic.
- Stores 0x10←0xA, 0x14←0xB, ack held 1 → two back-to-back writes in order, `stall` never high.
- 5 stores (DEPTH 4), ack held 0 → 5th store sees `stall`=1; one ack → 5th enqueues next cycle, tail wraps to index 0.
- Load from 0x20, empty buffer, `mem_rdata`=0xDEADBEEF, ack on first request cycle → `stall`=1 for 2 cycles, `rd_dm`=0xDEADBEEF in RDONE.
- Store 0x30←0x1 then load 0x30, without forwarding → write completes before read `mem_req`; stall = drain cycles + 2.
- With `DMEM_STORE_FWD_EN`: stores 0x40←0x1, 0x40←0x2, ack held 0, then load 0x40 → `rd_dm`=0x2, `stall`=0, no read issued.
